bch_chien_par: RTL and testbench



---
 rtl/bch_gf_pkg.sv | 47 ++++
 rtl/bch_gf_cmul.sv | 18 +
 rtl/bch_chien_par.sv | 163 ++++++++++++++++
 tb/tb_bch_chien_par.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_gf_pkg.sv
// GF(2^M) helpers for the BCH Chien stage: elaboration-time constant powers,
// constant-multiply XOR matrices and the Chien FSM state type.
package bch_gf_pkg;
    localparam int              GF_M    = 16;
    localparam logic [GF_M:0]   GF_POLY = 17'h1002D;

    typedef logic [GF_M-1:0]    gf_t;
    typedef gf_t [GF_M-1:0]     gf_mat_t;
    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN, ST_DONE} state_t;

    function automatic gf_t gf_mulx(gf_t a, logic [GF_M:0] poly);
        return {a[GF_M-2:0], 1'b0} ^ (a[GF_M-1] ? poly[GF_M-1:0] : '0);
    endfunction

    function automatic gf_t gf_mul(gf_t a, gf_t b, logic [GF_M:0] poly);
        gf_t r = '0;
        gf_t x = a;
        for (int i = 0; i < GF_M; i++) begin
            if (b[i]) r = r ^ x;
            x = gf_mulx(x, poly);
        end
        return r;
    endfunction

    function automatic gf_t gf_pow(int unsigned e, logic [GF_M:0] poly = GF_POLY);
        gf_t         r = gf_t'(1);
        gf_t         b = gf_t'(2);
        int unsigned x = e % ((32'd1 << GF_M) - 32'd1);
        while (x != 0) begin
            if ((x & 32'd1) != 0) r = gf_mul(r, b, poly);
            b = gf_mul(b, b, poly);
            x = x >> 1;
        end
        return r;
    endfunction

    // Row j is c*alpha^j, so y = XOR of rows selected by the set bits of the input.
    function automatic gf_mat_t gf_cmul_matrix(gf_t c, logic [GF_M:0] poly = GF_POLY);
        gf_mat_t m;
        gf_t     col = c;
        for (int j = 0; j < GF_M; j++) begin
            m[j] = col;
            col  = gf_mulx(col, poly);
        end
        return m;
    endfunction
endpackage

// File: rtl/bch_gf_cmul.sv
// Multiply by a constant field element as a pure XOR network.
module bch_gf_cmul
    import bch_gf_pkg::*;
#(
    parameter gf_t            C    = gf_t'(1),
    parameter logic [GF_M:0]  POLY = GF_POLY
)(
    input  gf_t i_a,
    output gf_t o_y
);
    localparam gf_mat_t MAT = gf_cmul_matrix(C, POLY);

    always_comb begin
        o_y = '0;
        for (int j = 0; j < GF_M; j++)
            if (i_a[j]) o_y = o_y ^ MAT[j];
    end
endmodule

// File: rtl/bch_chien_par.sv
// P-lane parallel Chien search and corrector. Define BCH_CHIEN_FAIL_DETECT_EN to
// build the root counter and decoding-failure flag; otherwise err_cnt/fail read 0.
module bch_chien_par
    import bch_gf_pkg::*;
#(
    parameter int            M      = GF_M,
    parameter logic [GF_M:0] POLY   = GF_POLY,
    parameter int            T      = 12,
    parameter int            N      = 16200,
    parameter int            K      = 16008,
    parameter int            P      = 8,
    parameter int            OFFSET = 1
)(
    input  logic                   clkofchian,
    input  logic                   rstofchian,
    input  logic                   start,
    input  logic [(T+1)*M-1:0]     lambda,
    output logic                   busy,
    input  logic [P-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [P-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   done,
    output logic [$clog2(T+1)-1:0] err_cnt,
    output logic                   fail
);
    localparam int BW = $clog2(N+1);
    localparam int CW = $clog2(T+1);

    state_t          r_state, w_next;
    gf_t             r_s [1:T];
    gf_t             r_l0;
    logic [BW-1:0]   r_base;
    gf_t             w_lam  [0:T];
    gf_t             w_init [1:T];
    gf_t             w_step [1:T];
    gf_t             w_term [1:T][0:P-1];
    gf_t             w_v    [0:P-1];
    logic [P-1:0]    w_err;
    logic            w_acc, w_data_beat;

    assign w_lam[0] = lambda[M-1:0];

    // s_k holds lambda_k*alpha^(k*(base+OFFSET)); lane p scales it by alpha^(k*p).
    for (genvar k = 1; k <= T; k++) begin : g_k
        assign w_lam[k]     = lambda[k*M +: M];
        assign w_term[k][0] = r_s[k];
        bch_gf_cmul #(.C(gf_pow(k*OFFSET, POLY)), .POLY(POLY)) u_init (.i_a(w_lam[k]), .o_y(w_init[k]));
        bch_gf_cmul #(.C(gf_pow(k*P, POLY)),      .POLY(POLY)) u_step (.i_a(r_s[k]),   .o_y(w_step[k]));
        for (genvar p = 1; p < P; p++) begin : g_p
            bch_gf_cmul #(.C(gf_pow(k*p, POLY)), .POLY(POLY)) u_lane (.i_a(r_s[k]), .o_y(w_term[k][p]));
        end
    end

    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_v[p] = r_l0;
            for (int k = 1; k <= T; k++) w_v[p] = w_v[p] ^ w_term[k][p];
            w_err[p] = (w_v[p] == '0);
        end
    end

    assign w_data_beat = (r_base < BW'(K));
    assign w_acc       = in_valid && in_ready;

    always_ff @(posedge clkofchian or posedge rstofchian) begin
        if (rstofchian) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_INIT;
            ST_INIT: w_next = ST_RUN;
            ST_RUN:  if (w_acc && r_base == BW'(N-P)) w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Parity beats never reach the output register, so they skip backpressure.
    always_comb begin
        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_DONE);
        in_ready = (r_state == ST_RUN) && (!w_data_beat || !out_valid || out_ready);
    end

    always_ff @(posedge clkofchian or posedge rstofchian) begin
        if (rstofchian) begin
            r_l0   <= '0;
            r_base <= '0;
            for (int k = 1; k <= T; k++) r_s[k] <= '0;
        end else if (r_state == ST_INIT) begin
            r_l0   <= w_lam[0];
            r_base <= '0;
            for (int k = 1; k <= T; k++) r_s[k] <= w_init[k];
        end else if (w_acc) begin
            r_base <= r_base + BW'(P);
            for (int k = 1; k <= T; k++) r_s[k] <= w_step[k];
        end
    end

    always_ff @(posedge clkofchian or posedge rstofchian) begin
        if (rstofchian) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (w_acc && w_data_beat) begin
            out_data  <= in_data ^ w_err;
            out_valid <= 1'b1;
            out_last  <= (r_base == BW'(K-P));
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef BCH_CHIEN_FAIL_DETECT_EN
    localparam int SW = $clog2(T+P+1);

    logic [CW-1:0] r_cnt, r_deg, w_deg;
    logic          r_sat;
    logic [SW-1:0] w_pop, w_sum;

    always_comb begin
        w_pop = '0;
        for (int p = 0; p < P; p++) w_pop = w_pop + SW'(w_err[p]);
        w_sum = SW'(r_cnt) + w_pop;
        w_deg = '0;
        for (int k = 1; k <= T; k++)
            if (w_lam[k] != '0) w_deg = CW'(k);
    end

    // More roots than T is impossible for a genuine locator: latch it as failure.
    always_ff @(posedge clkofchian or posedge rstofchian) begin
        if (rstofchian) begin
            r_cnt <= '0;
            r_deg <= '0;
            r_sat <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= '0;
            r_deg <= w_deg;
            r_sat <= 1'b0;
        end else if (w_acc) begin
            if (w_sum > SW'(T)) begin
                r_cnt <= CW'(T);
                r_sat <= 1'b1;
            end else begin
                r_cnt <= CW'(w_sum);
            end
        end
    end

    assign err_cnt = r_cnt;
    assign fail    = (r_cnt != r_deg) || r_sat;
`else
    assign err_cnt = '0;
    assign fail    = 1'b0;
`endif
endmodule

// File: tb/tb_bch_chien_par.sv
// Frame-level bench for bch_chien_par: table of frames plus a mid-frame reset sequence.
module tb_bch_chien_par;
    localparam int M  = 16;
    localparam int T  = 12;
    localparam int N  = 16200;
    localparam int K  = 16008;
    localparam int P  = 8;
    localparam int NB = N / P;
    localparam int KB = K / P;
    localparam int CW = $clog2(T+1);
`ifdef BCH_CHIEN_FAIL_DETECT_EN
    localparam bit FD = 1'b1;
`else
    localparam bit FD = 1'b0;
`endif

    typedef logic [(T+1)*M-1:0] lam_t;

    typedef struct {
        string name;
        bit    fixed;
        int    e0, e1, e2;
        int    exp_cnt;
        int    exp_fail;
        bit    bp;
    } vec_t;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
    lam_t          lambda = '0;
    logic          busy, in_ready, out_valid, out_last, done, fail;
    logic          in_valid = 1'b0, out_ready = 1'b1;
    logic [P-1:0]  in_data = '0, out_data;
    logic [CW-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bch_chien_par dut (
        .clkofchian(clk), .rstofchian(rst), .start(start), .lambda(lambda), .busy(busy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .done(done), .err_cnt(err_cnt), .fail(fail)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mulx(logic [15:0] a);
        return {a[14:0], 1'b0} ^ (a[15] ? 16'h002D : 16'h0000);
    endfunction

    function automatic logic [15:0] gmul(logic [15:0] a, logic [15:0] b);
        logic [15:0] r = '0;
        logic [15:0] x = a;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) r = r ^ x;
            x = mulx(x);
        end
        return r;
    endfunction

    function automatic logic [15:0] apow(int e);
        logic [15:0] r = 16'h0001;
        for (int i = 0; i < e % 65535; i++) r = mulx(r);
        return r;
    endfunction

    // Locator = product of (1 + alpha^-(i+1) x) over the listed error bits.
    function automatic lam_t mk_lambda(int e0, int e1, int e2);
        logic [15:0] c [T+1];
        int          e [3];
        logic [15:0] a;
        lam_t        r;
        e = '{e0, e1, e2};
        for (int k = 0; k <= T; k++) c[k] = '0;
        c[0] = 16'h0001;
        for (int j = 0; j < 3; j++) begin
            if (e[j] >= 0) begin
                a = apow(65535 - (e[j] + 1));
                for (int k = T; k >= 1; k--) c[k] = c[k] ^ gmul(a, c[k-1]);
            end
        end
        r = '0;
        for (int k = 0; k <= T; k++) r[k*M +: M] = c[k];
        return r;
    endfunction

    task automatic run_frame(input string nm, input lam_t lam, input int e0, input int e1, input int e2,
                             input int exp_cnt, input int exp_fail, input bit bp, input int abort_at);
        logic [P-1:0] orig [NB];
        logic [P-1:0] rx   [NB];
        int           e [3];
        int in_i = 0, out_i = 0, bad = 0, first_bad = -1, last_cnt = 0, last_at = -1;
        int done_cnt = 0, rdy_bad = 0, cyc = 0, cnt_at_done = -1, fail_at_done = -1;
        bit timed_out = 1'b0;
        e = '{e0, e1, e2};
        for (int b = 0; b < NB; b++) begin
            orig[b] = P'($urandom);
            rx[b]   = orig[b];
        end
        for (int j = 0; j < 3; j++)
            if (e[j] >= 0) rx[e[j] / P][e[j] % P] = ~rx[e[j] / P][e[j] % P];

        @(negedge clk);
        lambda = lam;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk({nm, "_busy"}, int'(busy), 1);

        forever begin
            if (cyc == 1) lambda = '1;
            in_valid  = (in_i < NB) && ($urandom_range(0, 7) != 0);
            in_data   = (in_i < NB) ? rx[in_i] : '0;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (in_i == 100);
            #1;
            if (done) begin
                done_cnt++;
                cnt_at_done  = int'(err_cnt);
                fail_at_done = int'(fail);
            end
            if (out_valid && !out_ready && in_ready && in_i < KB) rdy_bad++;
            if (out_valid && out_ready) begin
                if (out_i >= KB || out_data != orig[out_i]) begin
                    if (first_bad < 0) first_bad = out_i;
                    bad++;
                end
                if (out_last) begin
                    last_cnt++;
                    last_at = out_i;
                end
                out_i++;
            end
            if (in_valid && in_ready) in_i++;
            if (abort_at >= 0 && in_i == abort_at) break;
            if (done_cnt > 0 && out_i >= KB) break;
            if (cyc >= 20000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk({nm, "_timeout"}, int'(timed_out), 0);
        if (abort_at >= 0) return;

        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk({nm, "_bad_beats"}, bad, 0);
        if (bad != 0) $display("  %s first wrong beat index %0d", nm, first_bad);
        chk({nm, "_out_beats"}, out_i, KB);
        chk({nm, "_last_cnt"}, last_cnt, 1);
        chk({nm, "_last_at"}, last_at, KB - 1);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_err_cnt"}, cnt_at_done, exp_cnt);
        chk({nm, "_fail"}, fail_at_done, exp_fail);
        chk({nm, "_ready_under_bp"}, rdy_bad, 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        lam_t lam;
        int   sp;
        tbl[0] = '{"clean",   1'b0, -1,    -1,    -1,    0, 0, 1'b0};
        tbl[1] = '{"single",  1'b0, 37,    -1,    -1,    1, 0, 1'b0};
        tbl[2] = '{"triple",  1'b0, 0,     16007, 16199, 3, 0, 1'b0};
        tbl[3] = '{"bp",      1'b0, 37,    -1,    -1,    1, 0, 1'b1};
        tbl[4] = '{"noroots", 1'b1, -1,    -1,    -1,    0, 1, 1'b0};

        #3 rst = 1'b1;
        #10;
        chk("rst_busy",      int'(busy),      0);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last",  int'(out_last),  0);
        chk("rst_done",      int'(done),      0);
        chk("rst_err_cnt",   int'(err_cnt),   0);
        chk("rst_fail",      int'(fail),      0);
        chk("rst_out_data",  int'(out_data),  0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].fixed) begin
                lam = '0;
                lam[0 +: M] = 16'h0001;
                lam[M +: M] = 16'h0001;
                lam[2*M +: M] = 16'h0001;
            end else begin
                lam = mk_lambda(tbl[i].e0, tbl[i].e1, tbl[i].e2);
            end
            run_frame(tbl[i].name, lam, tbl[i].e0, tbl[i].e1, tbl[i].e2,
                      FD ? tbl[i].exp_cnt : 0, FD ? tbl[i].exp_fail : 0, tbl[i].bp, -1);
        end

        // Reset in the middle of a frame after 500 accepted beats.
        run_frame("abort", mk_lambda(37, -1, -1), 37, -1, -1, 0, 0, 1'b0, 500);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy",      int'(busy),      0);
        chk("midrst_in_ready",  int'(in_ready),  0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_last",  int'(out_last),  0);
        chk("midrst_err_cnt",   int'(err_cnt),   0);
        chk("midrst_out_data",  int'(out_data),  0);
        sp = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) sp++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (done || busy) sp++;
        end
        chk("midrst_spurious", sp, 0);
        run_frame("post_rst", mk_lambda(-1, -1, -1), -1, -1, -1, 0, 0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
